mem_march_bist: RTL and testbench
=================================

Name: mem_march_bist

Overview:
- Initiator side of the mem_top access interface (cen/rd/wr/add/din/dout).
- Drives a March C- self-test over the full address space.
- Checks every read against the expected background and reports pass/fail to the test controller.
- Sits between the chip test controller and one memory macro; in functional mode it releases the bus (cen high).

Parameters:
- ADDR_W, 12, address width; tested words N = 2**ADDR_W.
- DATA_W, 8, data width.
- RD_LAT, 1, cycles from the read-issue edge to valid mem_dout (1..4).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- busy  output  1  high while the test runs.
- done  output  1  high from test end until the next accepted start.
- pass  output  1  valid while done; 1 = zero miscompares.
- err_count  output  8  miscompare count, saturates at 255.
- fail_addr  output  ADDR_W  first failing address (BIST_DIAG_EN only).
- fail_exp  output  DATA_W  expected data at first fail (BIST_DIAG_EN only).
- fail_act  output  DATA_W  read data at first fail (BIST_DIAG_EN only).
- mem_cen  output  1  chip enable to memory, active-low.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_add  output  ADDR_W  memory address.
- mem_din  output  DATA_W  write data to memory.
- mem_dout  input  DATA_W  read data from memory.

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE; busy=0, done=0, pass=0, err_count=0, diag regs=0; mem_cen=1, mem_rd=0, mem_wr=0, mem_add=0, mem_din=0. Reset mid-test aborts immediately; no partial result is kept.
- Elements, run in order, with B0 = all-0 and B1 = all-1:
  - E0 ⇑ w0
  - E1 ⇑ r0,w1
  - E2 ⇑ r1,w0
  - E3 ⇓ r0,w1
  - E4 ⇓ r1,w0
  - E5 ⇑ r0
  - ⇑ runs addresses 0..N-1; ⇓ runs N-1..0.
- FSM states: IDLE, WR, RD, RWAIT, CMP, DONE.
- IDLE -> WR (E0) on start=1. The start edge clears err_count, done, pass and the diag regs; busy goes high the next cycle.
- WR, 1 cycle: mem_cen=0, mem_wr=1, mem_rd=0, mem_add=addr, mem_din=background.
- RD, 1 cycle: mem_cen=0, mem_rd=1, mem_wr=0.
- RWAIT, RD_LAT-1 cycles (skipped when RD_LAT=1): mem_cen=0, rd=0, wr=0, mem_add held.
- CMP, 1 cycle: samples mem_dout and compares it to the expected background. Strobes are low and mem_cen=0.
  - On mismatch: err_count+1, saturating.
  - Diag regs load on the first mismatch only.
- Within a read-write element the sequence per address is RD -> RWAIT -> CMP -> WR. The address then steps: +1 for ⇑, -1 for ⇓, with no wrap. After the last address the FSM moves to the next element.
- Cycle count is N*(1 + 4*(RD_LAT+2) + (RD_LAT+1)), i.e. 15N for RD_LAT=1.
- DONE, entered after the final CMP:
  - busy=0, done=1, pass=(err_count==0).
  - Memory bus returns to idle values.
  - Stays in DONE until start=1, then restarts as from IDLE.
- start while busy: ignored.
- A miscompare never stops the test; all elements always complete.

Optional Feature:
- BIST_DIAG_EN defined:
  - fail_addr, fail_exp and fail_act capture the first miscompare.
  - They hold until the next accepted start or reset.
- BIST_DIAG_EN undefined:
  - Capture registers are not built; the three ports are tied to 0.
  - err_count and pass are unchanged.

Test Plan:
- ADDR_W=4, RD_LAT=1, fault-free memory model; pulse start -> busy for 240 cycles, then done=1, pass=1, err_count=0. Bus cen=1, rd=0, wr=0 before start and after done.
- Same setup, model bit0 of address 0xA stuck-at-1 -> E1, E3 and E5 miscompare, giving err_count=3 and pass=0. With BIST_DIAG_EN: fail_addr=0xA, fail_exp=0x00, fail_act=0x01.
- Address order check -> E3 and E4 issue mem_add 0xF..0x0 descending; all other elements issue 0x0..0xF ascending. Each E0 write carries mem_din=0x00.
- RD_LAT=3, fault-free -> each read shows 2 RWAIT cycles; total 16*(1+4*5+4) = 400 cycles; pass=1.
- Drive rst low for 1 cycle mid-E2 -> all outputs and the bus return to reset values immediately. A new start yields a full 240-cycle run with pass=1.
- start re-pulsed while busy -> ignored, completion time unchanged. Model returning all 0xFF on every read -> err_count=48 (E1, E3, E5 fail every address) and pass=0.

Source files
------------

// File: rtl/mem_march_bist_if.sv
// Memory access bus between the BIST initiator (master) and one memory macro (slave).
interface mem_march_bist_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              mem_cen;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (output mem_cen, mem_rd, mem_wr, mem_add, mem_din, input mem_dout);
  modport slave  (input mem_cen, mem_rd, mem_wr, mem_add, mem_din, output mem_dout);
endinterface

// File: rtl/mem_march_bist.sv
// March C- memory BIST initiator over the full address space.
// Define BIST_DIAG_EN to build first-miscompare capture on fail_addr/fail_exp/fail_act.
module mem_march_bist #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  mem_march_bist_if.master  mem
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [1:0]        WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  // Elements 3 and 4 walk the address space downwards.
  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DATA_W-1:0] bg(input logic b);
    return b ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  logic [2:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [7:0]        err_q, err_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              busy_q, cen_q, rd_q, wr_q;
  logic [ADDR_W-1:0] add_q;
  logic [DATA_W-1:0] din_q;

  logic              last_addr_s, miscmp_s, active_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [DATA_W-1:0] exp_s;

  assign last_addr_s = is_down(elem_q) ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_MAX);
  assign next_addr_s = is_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
  // Reads in odd elements expect B0, in even elements B1.
  assign exp_s       = bg(~elem_q[0]);
  assign miscmp_s    = (state_q == S_CMP) && (mem.mem_dout != exp_s);
  assign active_s    = (state_d == S_WR) || (state_d == S_RD) ||
                       (state_d == S_RWAIT) || (state_d == S_CMP);

  // Next-state sequencing of March elements, addresses and result counters.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WR;
          elem_d  = 3'd0;
          addr_d  = ADDR_ZERO;
          err_d   = 8'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_WR: begin
        if (last_addr_s) begin
          elem_d  = elem_q + 3'd1;
          addr_d  = is_down(elem_q + 3'd1) ? ADDR_MAX : ADDR_ZERO;
          state_d = S_RD;
        end else begin
          addr_d  = next_addr_s;
          state_d = (elem_q == 3'd0) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (RD_LAT > 1) begin
          state_d = S_RWAIT;
          wcnt_d  = WAIT_INIT;
        end else begin
          state_d = S_CMP;
        end
      end
      S_RWAIT: begin
        if (wcnt_q == 2'd0) begin
          state_d = S_CMP;
        end else begin
          wcnt_d  = wcnt_q - 2'd1;
        end
      end
      S_CMP: begin
        if (miscmp_s && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end else begin
          err_d = err_q;
        end
        if (elem_q != 3'd5) begin
          state_d = S_WR;
        end else if (last_addr_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          addr_d  = next_addr_s;
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      addr_q  <= ADDR_ZERO;
      wcnt_q  <= 2'd0;
      err_q   <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      cen_q   <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      add_q   <= ADDR_ZERO;
      din_q   <= DATA_ZERO;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      busy_q  <= active_s;
      cen_q   <= ~active_s;
      rd_q    <= (state_d == S_RD);
      wr_q    <= (state_d == S_WR);
      add_q   <= active_s ? addr_d : ADDR_ZERO;
      din_q   <= (state_d == S_WR) ? bg(elem_d[0]) : DATA_ZERO;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign mem.mem_cen  = cen_q;
  assign mem.mem_rd   = rd_q;
  assign mem.mem_wr   = wr_q;
  assign mem.mem_add  = add_q;
  assign mem.mem_din  = din_q;

`ifdef BIST_DIAG_EN
  logic              start_acc_s;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_exp_q, fail_act_q;

  assign start_acc_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // First-miscompare capture; an accepted start clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_addr_q <= ADDR_ZERO;
      fail_exp_q  <= DATA_ZERO;
      fail_act_q  <= DATA_ZERO;
    end else if (start_acc_s) begin
      fail_addr_q <= ADDR_ZERO;
      fail_exp_q  <= DATA_ZERO;
      fail_act_q  <= DATA_ZERO;
    end else if (miscmp_s && (err_q == 8'd0)) begin
      fail_addr_q <= addr_q;
      fail_exp_q  <= exp_s;
      fail_act_q  <= mem.mem_dout;
    end else begin
      fail_addr_q <= fail_addr_q;
      fail_exp_q  <= fail_exp_q;
      fail_act_q  <= fail_act_q;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
`else
  assign fail_addr = ADDR_ZERO;
  assign fail_exp  = DATA_ZERO;
  assign fail_act  = DATA_ZERO;
`endif
endmodule

// File: tb/tb_mem_march_bist.sv
// Bench for mem_march_bist: two instances (RD_LAT=1 and RD_LAT=3) on 16-word memory models.
module tb_mem_march_bist;
  logic       clk = 1'b0;
  logic       rst;
  int         fault_mode;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic       start_v [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       pass_v  [2];
  logic [7:0] err_v   [2];
  logic [3:0] faddr_v [2];
  logic [7:0] fexp_v  [2];
  logic [7:0] fact_v  [2];
  logic       cen_v   [2];
  logic       rd_v    [2];
  logic       wr_v    [2];
  logic [3:0] add_v   [2];
  logic [7:0] din_v   [2];

  always #5 clk = ~clk;

  // Read-path fault injection: 1 = bit0 of word 0xA stuck-at-1, 2 = every read 0xFF.
  function automatic logic [7:0] fault_rd(input logic [7:0] d, input logic [3:0] a);
    if (fault_mode == 2) return 8'hFF;
    if (fault_mode == 1 && a == 4'hA) return d | 8'h01;
    return d;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] mem_arr [16];
    logic [7:0] pipe [4];

    mem_march_bist_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

    mem_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .pass(pass_v[g]), .err_count(err_v[g]), .fail_addr(faddr_v[g]),
      .fail_exp(fexp_v[g]), .fail_act(fact_v[g]), .mem(ifc)
    );

    assign cen_v[g] = ifc.mem_cen;
    assign rd_v[g]  = ifc.mem_rd;
    assign wr_v[g]  = ifc.mem_wr;
    assign add_v[g] = ifc.mem_add;
    assign din_v[g] = ifc.mem_din;
    assign ifc.mem_dout = pipe[L-1];

    // Synchronous memory: read data appears L cycles after the read-issue edge, garbage otherwise.
    always @(posedge clk) begin
      if (!ifc.mem_cen && ifc.mem_wr) mem_arr[ifc.mem_add] <= ifc.mem_din;
      pipe[0] <= (!ifc.mem_cen && ifc.mem_rd) ? fault_rd(mem_arr[ifc.mem_add], ifc.mem_add) : 8'h5A;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
  end

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       chk_add;
    logic [3:0] add;
    logic [7:0] din;
  } cyc_t;

  cyc_t       exp_q [$];
  int         exp_err;
  logic [3:0] exp_faddr;
  logic [7:0] exp_fexp, exp_fact;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // March C- as an operation list: expected bus cycles plus expected miscompare results.
  task automatic build_model(input int lat);
    logic [7:0] ref_mem [16];
    logic [3:0] a;
    logic [7:0] rv, wv, got;
    exp_q.delete();
    exp_err = 0; exp_faddr = 4'h0; exp_fexp = 8'h00; exp_fact = 8'h00;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        a = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
        if (e != 0) begin
          rv  = (e == 2 || e == 4) ? 8'hFF : 8'h00;
          got = fault_rd(ref_mem[a], a);
          if (got != rv) begin
            if (exp_err == 0) begin exp_faddr = a; exp_fexp = rv; exp_fact = got; end
            if (exp_err < 255) exp_err++;
          end
          exp_q.push_back('{1'b1, 1'b0, 1'b1, a, 8'h00});
          for (int w = 1; w < lat; w++) exp_q.push_back('{1'b0, 1'b0, 1'b1, a, 8'h00});
          exp_q.push_back('{1'b0, 1'b0, 1'b0, a, 8'h00});
        end
        if (e != 5) begin
          wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
          ref_mem[a] = wv;
          exp_q.push_back('{1'b0, 1'b1, 1'b1, a, wv});
        end
      end
    end
  endtask

  task automatic check_reset_vals(input int g, input string tag);
    chk({tag, "_busy"}, 32'(busy_v[g]), 32'd0);
    chk({tag, "_done"}, 32'(done_v[g]), 32'd0);
    chk({tag, "_pass"}, 32'(pass_v[g]), 32'd0);
    chk({tag, "_err"},  32'(err_v[g]),  32'd0);
    chk({tag, "_bus"},  {17'd0, cen_v[g], rd_v[g], wr_v[g], add_v[g], din_v[g]}, {17'd0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00});
    chk({tag, "_diag"}, {12'd0, faddr_v[g], fexp_v[g], fact_v[g]}, 32'd0);
  endtask

  // Start one run and compare every busy cycle and the final result against the model.
  task automatic run_check(input int g, input int lat, input int repulse_at, input string tag);
    cyc_t c;
    build_model(lat);
    chk({tag, "_pre_busy"}, 32'(busy_v[g]), 32'd0);
    chk({tag, "_pre_bus"}, {29'd0, cen_v[g], rd_v[g], wr_v[g]}, {29'd0, 3'b100});
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      c = exp_q[k];
      start_v[g] = (k == repulse_at);
      chk($sformatf("%s_cyc%0d", tag, k),
          {15'd0, busy_v[g], done_v[g], cen_v[g], rd_v[g], wr_v[g],
           c.chk_add ? add_v[g] : 4'h0, c.wr ? din_v[g] : 8'h00},
          {15'd0, 1'b1, 1'b0, 1'b0, c.rd, c.wr,
           c.chk_add ? c.add : 4'h0, c.wr ? c.din : 8'h00});
      @(negedge clk);
    end
    start_v[g] = 1'b0;
    chk({tag, "_done"}, 32'(done_v[g]), 32'd1);
    chk({tag, "_busy"}, 32'(busy_v[g]), 32'd0);
    chk({tag, "_pass"}, 32'(pass_v[g]), 32'(exp_err == 0));
    chk({tag, "_err"},  32'(err_v[g]),  32'(exp_err));
    chk({tag, "_post_bus"}, {29'd0, cen_v[g], rd_v[g], wr_v[g]}, {29'd0, 3'b100});
`ifdef BIST_DIAG_EN
    chk({tag, "_diag"}, {12'd0, faddr_v[g], fexp_v[g], fact_v[g]}, {12'd0, exp_faddr, exp_fexp, exp_fact});
`else
    chk({tag, "_diag"}, {12'd0, faddr_v[g], fexp_v[g], fact_v[g]}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    fault_mode = 0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clk);
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    rst = 1'b1;
    @(negedge clk);

    run_check(0, 1, -1, "clean");
    chk("m_len240", 32'(exp_q.size()), 32'd240);
    chk("m_e3_first_add", 32'(exp_q[112].add), 32'h0F);

    fault_mode = 1;
    run_check(0, 1, -1, "sa1");
    chk("m_err3", 32'(exp_err), 32'd3);
    chk("m_fdiag", {12'd0, exp_faddr, exp_fexp, exp_fact}, {12'd0, 4'hA, 8'h00, 8'h01});
    chk("sa1_err_lit", 32'(err_v[0]), 32'd3);

    fault_mode = 0;
    run_check(1, 3, -1, "lat3");
    chk("m_len400", 32'(exp_q.size()), 32'd400);

    // Reset in the middle of E2 with 16 errors already counted.
    fault_mode = 2;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (69) @(negedge clk);
    chk("mid_busy", 32'(busy_v[0]), 32'd1);
    chk("mid_err", 32'(err_v[0]), 32'd16);
    #1 rst = 1'b0;
    #1 check_reset_vals(0, "async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals(0, "after_rst");

    fault_mode = 0;
    run_check(0, 1, -1, "rerun");

    fault_mode = 2;
    run_check(0, 1, 100, "allff");
    chk("m_err48", 32'(exp_err), 32'd48);
    chk("allff_pass_lit", 32'(pass_v[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
